// File: rtl/ca_random_pkg.sv
// Shared constants and types for the cellular-automaton random sources.
package ca_random_pkg;

    localparam logic [7:0] RULE30  = 8'h1E;
    localparam logic [7:0] RULE60  = 8'h3C;
    localparam logic [7:0] RULE90  = 8'h5A;
    localparam logic [7:0] RULE150 = 8'h96;

    localparam logic [31:0] DefaultRuleTable = {RULE150, RULE90, RULE60, RULE30};

    typedef enum logic [0:0] {WARMUP, RUN} ca_state_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ca_ring_step.sv
// One combinational step of an elementary cellular automaton on a wrapped ring.
module ca_ring_step #(
    parameter int unsigned Cells = 12
) (
    input  logic [Cells-1:0] state_i,
    input  logic [7:0]       rule_i,
    output logic [Cells-1:0] next_o
);

    for (genvar i = 0; i < Cells; i++) begin : g_cell
        localparam int unsigned Left  = (i + 1) % Cells;
        localparam int unsigned Right = (i + Cells - 1) % Cells;
        assign next_o[i] = rule_i[{state_i[Left], state_i[i], state_i[Right]}];
    end

endmodule

// File: rtl/ca_parity_random_gen.sv
// Cellular-automaton random word generator with rule rotation, seeding, warm-up
// and a valid/ready output handshake.
module ca_parity_random_gen
    import ca_random_pkg::*;
#(
    parameter int unsigned Width        = 32,
    parameter int unsigned ParitWidth   = 3,
    parameter int unsigned CAWidth      = Width * ParitWidth,
    parameter int unsigned RuleCount    = 4,
    parameter int unsigned RuleHold     = 2,
    parameter int unsigned WarmupCycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_load,
    input  logic [CAWidth-1:0]     seed,
    input  logic [8*RuleCount-1:0] rule_table,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [Width-1:0]       random,
    output logic                   busy
);

    localparam int unsigned IdxW  = cnt_width(RuleCount);
    localparam int unsigned HoldW = cnt_width(RuleHold);
    localparam int unsigned WarmW = cnt_width(WarmupCycles);

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(RuleCount - 1);
    localparam logic [HoldW-1:0] LastHold = HoldW'(RuleHold - 1);
    localparam logic [WarmW-1:0] LastWarm = WarmW'(WarmupCycles - 1);

    // Alternating 0101... pattern with bit 0 set, also used for an all-zero seed.
    localparam logic [2*CAWidth-1:0] AltWide      = {CAWidth{2'b01}};
    localparam logic [CAWidth-1:0]   ResetPattern = AltWide[CAWidth-1:0];

    ca_state_e          state_q;
    logic [CAWidth-1:0] cells_q;
    logic [CAWidth-1:0] cells_step;
    logic [IdxW-1:0]    rule_idx_q;
    logic [HoldW-1:0]   hold_cnt_q;
    logic [WarmW-1:0]   warm_cnt_q;
    logic [7:0]         rule_cur;
    logic               step;

    always_comb begin
        rule_cur = '0;
        for (int unsigned k = 0; k < RuleCount; k++) begin
            if (rule_idx_q == IdxW'(k)) begin
                rule_cur = rule_table[8*k +: 8];
            end
        end
    end

    ca_ring_step #(
        .Cells(CAWidth)
    ) u_ring_step (
        .state_i(cells_q),
        .rule_i (rule_cur),
        .next_o (cells_step)
    );

    // Warm-up free-runs; in RUN the ring only advances on an accepted word.
    assign step = (state_q == WARMUP) || (out_valid && out_ready);

    for (genvar j = 0; j < Width; j++) begin : g_fold
        assign random[j] = (^cells_q[j*ParitWidth +: ParitWidth]) ^ ((j % 2) == 0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WARMUP;
            cells_q    <= ResetPattern;
            rule_idx_q <= '0;
            hold_cnt_q <= '0;
            warm_cnt_q <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b1;
        end else if (seed_load) begin
            state_q    <= WARMUP;
            cells_q    <= (seed == '0) ? ResetPattern : seed;
            rule_idx_q <= '0;
            hold_cnt_q <= '0;
            warm_cnt_q <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b1;
        end else if (step) begin
            cells_q <= cells_step;

            if (hold_cnt_q == LastHold) begin
                hold_cnt_q <= '0;
                rule_idx_q <= (rule_idx_q == LastIdx) ? '0 : rule_idx_q + 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end

            if (state_q == WARMUP) begin
                if (warm_cnt_q == LastWarm) begin
                    state_q    <= RUN;
                    warm_cnt_q <= '0;
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                end else begin
                    warm_cnt_q <= warm_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ca_parity_random_gen.sv
// Scoreboard bench for ca_parity_random_gen against a step-count based reference model.
module tb_ca_parity_random_gen;
    import ca_random_pkg::*;

    localparam int unsigned Width        = 4;
    localparam int unsigned ParitWidth   = 3;
    localparam int unsigned CAWidth      = 12;
    localparam int unsigned RuleCount    = 4;
    localparam int unsigned RuleHold     = 2;
    localparam int unsigned WarmupCycles = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [11:0] seed;
    logic [31:0] rule_table;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  random;
    logic        busy;

    ca_parity_random_gen #(
        .Width       (Width),
        .ParitWidth  (ParitWidth),
        .CAWidth     (CAWidth),
        .RuleCount   (RuleCount),
        .RuleHold    (RuleHold),
        .WarmupCycles(WarmupCycles)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .rule_table(rule_table),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .random    (random),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    // Reference model: cell vector, steps since reset/seed, warm-up steps remaining.
    logic [11:0] m_cells;
    int          m_steps;
    int          m_warm_left;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rule_for(input int steps);
        int entry = (steps / RuleHold) % RuleCount;
        return rule_table[8*entry +: 8];
    endfunction

    function automatic logic [11:0] ca_next(input logic [11:0] c, input logic [7:0] r);
        logic [11:0] n = '0;
        for (int i = 0; i < 12; i++) begin
            int idx = 4 * c[(i + 1) % 12] + 2 * c[i] + c[(i + 11) % 12];
            n[i] = r[idx];
        end
        return n;
    endfunction

    function automatic logic [3:0] word_of(input logic [11:0] c);
        logic [3:0] w = '0;
        for (int j = 0; j < 4; j++) begin
            int ones = 0;
            for (int k = 0; k < 3; k++) ones += int'(c[3*j + k]);
            w[j] = ((ones % 2) == 1) != ((j % 2) == 0);
        end
        return w;
    endfunction

    task automatic model_reset(input logic [11:0] c);
        m_cells     = c;
        m_steps     = 0;
        m_warm_left = WarmupCycles;
    endtask

    task automatic model_step();
        m_cells = ca_next(m_cells, rule_for(m_steps));
        m_steps++;
    endtask

    // One clock with the given out_ready; expected words go to the scoreboard queue.
    task automatic tick(input logic rdy);
        logic handshake;
        out_ready = rdy;
        handshake = (m_warm_left == 0) && rdy;
        if (handshake) exp_q.push_back(word_of(m_cells));
        @(posedge clk);
        if (m_warm_left > 0) begin
            model_step();
            m_warm_left--;
        end else if (handshake) begin
            model_step();
        end
        #1;
        if (m_warm_left == 0 && !rdy) check_word("hold_stable", random, word_of(m_cells));
    endtask

    task automatic load_seed(input logic [11:0] s, input logic rdy);
        seed      = s;
        seed_load = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        out_ready = 1'b0;
        model_reset((s == 12'h000) ? 12'h555 : s);
        check_bit("seed_valid", out_valid, 1'b0);
        check_bit("seed_busy", busy, 1'b1);
        check_word("seed_word", random, word_of(m_cells));
    endtask

    task automatic warmup_check(input string tag);
        repeat (WarmupCycles - 1) tick(1'b0);
        check_bit({tag, "_valid_early"}, out_valid, 1'b0);
        check_bit({tag, "_busy_early"}, busy, 1'b1);
        tick(1'b0);
        check_bit({tag, "_valid"}, out_valid, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_word({tag, "_word"}, random, word_of(m_cells));
    endtask

    task automatic reset_check(input string tag);
        check_word({tag, "_random"}, random, 4'hF);
        check_bit({tag, "_valid"}, out_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b1);
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] exp_word;
        if (!rst && !seed_load && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got word %h, expected no handshake", random);
            end else begin
                exp_word = exp_q.pop_front();
                check_word("sb_word", random, exp_word);
            end
        end
    end

    initial begin
        logic [3:0]  hold_word;
        logic [11:0] s;

        rst        = 1'b1;
        seed_load  = 1'b0;
        seed       = '0;
        out_ready  = 1'b0;
        rule_table = DefaultRuleTable;
        repeat (2) @(posedge clk);
        #2;
        reset_check("por");
        rst = 1'b0;
        model_reset(12'h555);
        warmup_check("por_warm");
        repeat (4) tick(1'b0);
        repeat (24) tick(1'($urandom_range(0, 1)));

        // Constant rules force the ring to all-zero / all-one.
        rule_table = {4{8'h00}};
        load_seed(12'hABC, 1'b0);
        warmup_check("zero_rule");
        check_word("zero_word", random, 4'h5);
        rule_table = {4{8'hFF}};
        load_seed(12'hABC, 1'b0);
        warmup_check("ones_rule");
        check_word("ones_word", random, 4'hA);

        // Rotate-left rule: 16 warm-up steps move bit 11 to bit 3, 12 more wrap around.
        rule_table = {4{8'hAA}};
        load_seed(12'h800, 1'b0);
        warmup_check("rot");
        check_word("rot_word", random, 4'h7);
        repeat (12) tick(1'b1);
        check_word("rot_wrap", random, 4'h7);

        // Identity rule: output never moves under random back-pressure.
        rule_table = {4{8'hCC}};
        s = 12'($urandom()) | 12'h001;
        load_seed(s, 1'b0);
        warmup_check("ident");
        hold_word = word_of(m_cells);
        repeat (30) begin
            tick(1'($urandom_range(0, 1)));
            check_word("ident_word", random, hold_word);
        end

        // Random rule tables exercise the rule rotation schedule.
        repeat (3) begin
            rule_table = $urandom();
            s = 12'($urandom()) | 12'h010;
            load_seed(s, 1'b0);
            warmup_check("sched");
            repeat (30) tick(1'($urandom_range(0, 1)));
        end

        // Zero seed during an active handshake: handshake dropped, reset pattern loaded.
        repeat (3) tick(1'b1);
        load_seed(12'h000, 1'b1);
        check_word("zseed_word", random, 4'hF);
        warmup_check("zseed");

        // Asynchronous reset mid-warm-up, then again in RUN.
        rule_table = DefaultRuleTable;
        load_seed(12'h3A7, 1'b0);
        repeat (7) tick(1'b0);
        #3 rst = 1'b1;
        #1 reset_check("mid_warm_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset(12'h555);
        warmup_check("mid_warm_rel");
        repeat (3) tick(1'b1);
        #3 rst = 1'b1;
        #1 reset_check("run_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset(12'h555);
        warmup_check("run_rel");
        repeat (10) tick(1'($urandom_range(0, 1)));

        check_bit("sb_drained", exp_q.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
